// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module   : alu_mul_seq (with embedded Hack ALU `alu`)
//  Purpose  : Multi-cycle 16x16 -> 16 shift-and-add multiplier that borrows
//             the Hack ALU as its only adder and reuses it for result flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] w_x0;
    logic [15:0] w_x1;
    logic [15:0] w_y0;
    logic [15:0] w_y1;
    logic [15:0] w_f;

    assign w_x0 = zx ? 16'h0000 : x;
    assign w_x1 = nx ? ~w_x0 : w_x0;
    assign w_y0 = zy ? 16'h0000 : y;
    assign w_y1 = ny ? ~w_y0 : w_y0;
    assign w_f  = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    assign out  = no ? ~w_f : w_f;
    assign zr   = (out == 16'h0000);
    assign ng   = out[15];

endmodule

module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_acc;
    logic [15:0] r_mc;
    logic [15:0] r_mp;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_zr;
    logic        r_ng;

    logic        w_add;
    logic        w_last;
    logic [15:0] w_alu_out;
    logic        w_alu_zr;
    logic        w_alu_ng;

    // On a RUN cycle whose multiplier bit is 0 the ALU passes acc through
    // unchanged, so its flags always describe the next accumulator value and
    // can be captured on the RUN->DONE edge without a second flag path.
    assign w_add  = (r_state == S_RUN) && r_mp[0];
    assign w_last = (r_cnt == 4'd15) || (EARLY_EXIT && (r_mp[15:1] == 15'd0));

    alu u_alu (
        .x   (r_acc),
        .y   (r_mc),
        .zx  (1'b0),
        .nx  (1'b0),
        .zy  (~w_add),
        .ny  (~w_add),
        .f   (w_add),
        .no  (1'b0),
        .out (w_alu_out),
        .zr  (w_alu_zr),
        .ng  (w_alu_ng)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= 16'h0000;
            r_mc    <= 16'h0000;
            r_mp    <= 16'h0000;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_zr    <= 1'b1;
            r_ng    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_zr <= w_alu_zr;
                    r_ng <= w_alu_ng;
                    if (start) begin
                        r_acc   <= 16'h0000;
                        r_mc    <= a;
                        r_mp    <= b;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_alu_out;
                    r_mc  <= {r_mc[14:0], 1'b0};
                    r_mp  <= {1'b0, r_mp[15:1]};
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_zr    <= w_alu_zr;
                        r_ng    <= w_alu_ng;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_zr    <= w_alu_zr;
                    r_ng    <= w_alu_ng;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;
    assign zr      = r_zr;
    assign ng      = r_ng;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
//  Module   : tb_alu_mul_seq
//  Purpose  : Scoreboard bench for alu_mul_seq, EARLY_EXIT=1 (index 0) and
//             EARLY_EXIT=0 (index 1) instances side by side.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [2];
    logic [15:0] a_v     [2];
    logic [15:0] b_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic [15:0] prod_v  [2];
    logic        zr_v    [2];
    logic        ng_v    [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   pushed [2];
    int   seen   [2];

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] vp [8];

    alu_mul_seq #(.EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .product(prod_v[0]),
        .zr(zr_v[0]), .ng(ng_v[0])
    );

    alu_mul_seq #(.EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .product(prod_v[1]),
        .zr(zr_v[1]), .ng(ng_v[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input int d, input logic [15:0] bb);
        int k;
        k = 1;
        if (d == 1) return 17;
        for (int i = 0; i < 16; i++) if (bb[i]) k = i + 1;
        return 1 + k;
    endfunction

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT at cycle %0d", name, cyc);
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        while (busy_v[d] !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout_fail($sformatf("wait_idle_d%0d", d));
    endtask

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic issue(input int d, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] ip, input bit push, input bit hold);
        exp_t e;
        wait_idle(d);
        a_v[d]     = ia;
        b_v[d]     = ib;
        start_v[d] = 1'b1;
        @(negedge clk);
        if (!hold) start_v[d] = 1'b0;
        check($sformatf("busy_rise_d%0d", d), {31'd0, busy_v[d]}, 32'd1);
        if (push) begin
            e.a       = ia;
            e.b       = ib;
            e.prod    = ip;
            e.lat     = exp_lat(d, ib);
            e.acc_cyc = cyc;
            if (d == 0) sb0.push_back(e); else sb1.push_back(e);
            pushed[d]++;
        end
    endtask

    task automatic on_done(input int d);
        exp_t e;
        int   n;
        seen[d]++;
        n = (d == 0) ? sb0.size() : sb1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done_d%0d: done=1 with nothing pending, product=%0h", d, prod_v[d]);
        end else begin
            if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            check($sformatf("product_d%0d a=%h b=%h", d, e.a, e.b), {16'd0, prod_v[d]}, {16'd0, e.prod});
            check($sformatf("zr_d%0d a=%h b=%h", d, e.a, e.b), {31'd0, zr_v[d]}, {31'd0, e.prod == 16'h0000});
            check($sformatf("ng_d%0d a=%h b=%h", d, e.a, e.b), {31'd0, ng_v[d]}, {31'd0, e.prod[15]});
            check($sformatf("latency_d%0d b=%h", d, e.b), cyc - e.acc_cyc + 1, e.lat);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) if (done_v[d] === 1'b1) on_done(d);
    end

    task automatic run_directed(input int d);
        int t;
        for (int i = 0; i < 8; i++) begin
            issue(d, va[i], vb[i], vp[i], 1'b1, 1'b0);
            wait_idle(d);
            repeat (3) @(negedge clk);
            check($sformatf("product_hold_d%0d_v%0d", d, i), {16'd0, prod_v[d]}, {16'd0, vp[i]});
        end
        // Start pulses while busy, including the DONE cycle, must be ignored.
        issue(d, 16'd3, 16'd5, 16'd15, 1'b1, 1'b0);
        t = 0;
        while (busy_v[d] === 1'b1 && t < 200) begin
            a_v[d]     = 16'h0100 + 16'(t);
            b_v[d]     = 16'h0009;
            start_v[d] = 1'b1;
            @(negedge clk);
            t++;
        end
        start_v[d] = 1'b0;
        if (t >= 200) timeout_fail($sformatf("ignore_busy_d%0d", d));
        repeat (4) @(negedge clk);
        check($sformatf("ignored_start_idle_d%0d", d), {31'd0, busy_v[d]}, 32'd0);
        check($sformatf("ignored_start_prod_d%0d", d), {16'd0, prod_v[d]}, 32'd15);
    endtask

    task automatic run_random(input int d);
        logic [15:0] ia;
        logic [15:0] ib;
        logic [31:0] p;
        for (int i = 0; i < 1000; i++) begin
            ia = 16'($urandom);
            ib = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            p  = 32'(ia) * 32'(ib);
            issue(d, ia, ib, p[15:0], 1'b1, 1'b1);
        end
        start_v[d] = 1'b0;
        wait_idle(d);
    endtask

    initial begin
        int t;
        va[0] = 16'h0003; vb[0] = 16'h0005; vp[0] = 16'h000F;
        va[1] = 16'h1234; vb[1] = 16'h0000; vp[1] = 16'h0000;
        va[2] = 16'hFFFF; vb[2] = 16'h0007; vp[2] = 16'hFFF9;
        va[3] = 16'h0100; vb[3] = 16'h0100; vp[3] = 16'h0000;
        va[4] = 16'h7FFF; vb[4] = 16'h0002; vp[4] = 16'hFFFE;
        va[5] = 16'h0003; vb[5] = 16'h8000; vp[5] = 16'h8000;
        va[6] = 16'hFFFF; vb[6] = 16'hFFFF; vp[6] = 16'h0001;
        va[7] = 16'h00C8; vb[7] = 16'h0019; vp[7] = 16'h1388;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            a_v[d]     = 16'h0000;
            b_v[d]     = 16'h0000;
            pushed[d]  = 0;
            seen[d]    = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy_d%0d", d), {31'd0, busy_v[d]}, 32'd0);
            check($sformatf("rst_done_d%0d", d), {31'd0, done_v[d]}, 32'd0);
            check($sformatf("rst_product_d%0d", d), {16'd0, prod_v[d]}, 32'd0);
            check($sformatf("rst_zr_d%0d", d), {31'd0, zr_v[d]}, 32'd1);
            check($sformatf("rst_ng_d%0d", d), {31'd0, ng_v[d]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Abort an operation mid-RUN; no done may follow.
        issue(0, 16'd7, 16'd9, 16'd63, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_busy", {31'd0, busy_v[0]}, 32'd0);
        check("midrun_reset_product", {16'd0, prod_v[0]}, 32'd0);
        check("midrun_reset_zr", {31'd0, zr_v[0]}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);

        fork
            run_directed(0);
            run_directed(1);
        join
        fork
            run_random(0);
            run_random(1);
        join

        t = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("sb_empty_d0", sb0.size(), 0);
        check("sb_empty_d1", sb1.size(), 0);
        check("done_count_d0", seen[0], pushed[0]);
        check("done_count_d1", seen[1], pushed[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle 16-bit multiplier sequencer built around one instance of the team's Hack ALU (`alu`), which has no native multiply. The sequencer drives the six ALU control bits each cycle to run a shift-and-add loop. It exposes a start/busy/done handshake to a CPU-side requester. When idle, the same ALU is reused in pass-through mode to produce zr/ng flags for the held product.

Parameters:
EARLY_EXIT, 1, 1 = stop the loop once the remaining multiplier is zero; 0 = always run 16 iterations.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled only while busy=0
a  input  16  multiplicand, captured on accepted start
b  input  16  multiplier, captured on accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; product valid from this cycle on
product  output  16  low 16 bits of a*b (two's-complement wrap), held until next accepted start
zr  output  1  product == 0
ng  output  1  product[15]

Behaviour:
- Reset (async assert, state cleared immediately): state=IDLE, acc=0, mc=0, mp=0, cnt=0, busy=0, done=0, product=0. With product=0, zr=1 and ng=0.
- Registers:
  - acc: 16-bit accumulator; drives product.
  - mc: multiplicand, shifted left 1 per iteration, zero-fill.
  - mp: multiplier, shifted right 1 per iteration, logical shift.
  - cnt: 4-bit iteration counter.
- ALU connections: x=acc, y=mc. The ALU is the only adder in the block; no local '+' operator.
- States:
  - IDLE: busy=0.
    - On start=1 at a clk edge: acc<=0, mc<=a, mp<=b, cnt<=0, go to RUN.
    - start=0: stay in IDLE.
  - RUN: busy=1. ALU controls zx=0 nx=0 zy=0 ny=0 f=1 no=0, so alu out = acc+mc.
    - Each edge: if mp[0]=1 then acc<=alu out, else acc holds; mc<=mc<<1; mp<=mp>>1; cnt<=cnt+1.
    - Exit to DONE when cnt==15, or when EARLY_EXIT=1 and (mp>>1)==0.
  - DONE: busy=1, done=1 for exactly one cycle. Next edge goes to IDLE.
    - A start in DONE is ignored; start is accepted again only from IDLE.
- Flag mode (IDLE and DONE): ALU controls zx=0 nx=0 zy=1 ny=1 f=0 no=0, so out = acc & 0xFFFF = acc.
  - zr and ng come from the ALU zr/ng outputs in this mode and are registered on each edge.
  - During RUN, zr/ng hold their last value.
  - zr/ng are valid in the DONE cycle; the flag register is updated from the acc/product value at the RUN→DONE edge.
- Latency, start edge to done-high cycle:
  - EARLY_EXIT=1: 1 + k cycles, where k = max(1, index of highest set bit of b + 1).
  - EARLY_EXIT=0: always 17 cycles.
  - b=0 gives k=1.
- Arithmetic: modulo 2^16. Signed operands give the correct low 16 bits with no special handling. Overflow is silently discarded.
- Start held high continuously: a new operation begins each time IDLE is re-entered. Back-to-back throughput is latency + 1 cycles.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, and the block returns to reset values.
- a/b changing after capture has no effect.

Test Plan:
1. Reset with start=0 → busy=0, done=0, product=0, zr=1, ng=0. Assert reset mid-RUN (a=7, b=9) → busy drops asynchronously; no done ever pulses.
2. a=3, b=5, EARLY_EXIT=1 → busy rises the next cycle; done pulses once at start+4; product=15, zr=0, ng=0; product holds 15 afterwards.
3. a=0x1234, b=0 → done at start+2; product=0, zr=1. Same operands with EARLY_EXIT=0 → done at start+17; product=0.
4. a=0xFFFF (−1), b=0x0007 → product=0xFFF9 (−7), ng=1. Then a=0x0100, b=0x0100 → product=0x0000 (wrap), zr=1.
5. Pulse start again while busy (including in the DONE cycle) with different a/b → ignored; result matches the first operands only.
6. Random a/b over 1000 operations with start held high, for both EARLY_EXIT values → product == (a*b) mod 2^16; exactly one done per operation; latency matches the formula.
